adc_clk_gen: RTL and testbench



---
 rtl/adc_clk_gen_pkg.sv | 12 +
 rtl/adc_clk_div_core.sv | 61 ++++++
 rtl/adc_clk_gen.sv | 99 +++++++++
 tb/tb_adc_clk_gen.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/adc_clk_gen_pkg.sv
// ADC clock generator shared types.
// State encoding and divisor limits.
package adc_clk_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int MIN_DIV = 1;

endpackage

// File: rtl/adc_clk_div_core.sv
// Divider core: period position counter, divisor shadow, clk_out flop.
// Ports: aclk/resetn, load (start or reload), run_nxt, div_eff in; pos, d_act, at_wrap, clk_out out.
module adc_clk_div_core
  import adc_clk_gen_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic                 run_nxt,
  input  logic [DIV_WIDTH-1:0] div_eff,
  output logic [DIV_WIDTH:0]   pos,
  output logic [DIV_WIDTH-1:0] d_act,
  output logic                 at_wrap,
  output logic                 clk_out
);

  localparam logic [DIV_WIDTH:0] ONE = {{DIV_WIDTH{1'b0}}, 1'b1};

  logic [DIV_WIDTH:0]   pos_q, pos_d;
  logic [DIV_WIDTH-1:0] d_act_q, d_act_d;
  logic                 clk_out_q, clk_out_d;
  logic [DIV_WIDTH:0]   span;

  // Last position of the period: 2*D_act-1.
  assign span = {d_act_q, 1'b0} - ONE;
  assign at_wrap = (pos_q == span);

  always_comb begin
    pos_d   = pos_q;
    d_act_d = d_act_q;
    if (load) begin
      pos_d   = '0;
      d_act_d = div_eff;
    end else if (run_nxt) begin
      pos_d = pos_q + ONE;
    end else begin
      pos_d = '0;
    end
    // High for the first half of the period, computed from next pos.
    clk_out_d = run_nxt && ({1'b0, d_act_d} > pos_d);
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      pos_q     <= '0;
      d_act_q   <= DIV_WIDTH'(MIN_DIV);
      clk_out_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      d_act_q   <= d_act_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign pos     = pos_q;
  assign d_act   = d_act_q;
  assign clk_out = clk_out_q;

endmodule

// File: rtl/adc_clk_gen.sv
// ADC sampling clock generator with run/stop FSM, strobe and edge counter.
// Ports: aclk/resetn, enable, div_half, strobe_phase in; clk_out, clk_running, sample_strobe, edge_count out.
module adc_clk_gen
  import adc_clk_gen_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_half,
  input  logic [DIV_WIDTH:0]   strobe_phase,
  output logic                 clk_out,
  output logic                 clk_running,
  output logic                 sample_strobe,
  output logic [CNT_WIDTH-1:0] edge_count
);

  localparam logic [DIV_WIDTH:0] ONE = {{DIV_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 load;
  logic                 run_nxt;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DIV_WIDTH:0]   pos;
  logic [DIV_WIDTH-1:0] d_act;
  logic                 at_wrap;
  logic [DIV_WIDTH:0]   phase_q, phase_d;
  logic [DIV_WIDTH:0]   span;
  logic [DIV_WIDTH:0]   p_eff;
  logic [CNT_WIDTH-1:0] edge_count_q, edge_count_d;

  assign div_eff = (div_half == '0) ? DIV_WIDTH'(MIN_DIV) : div_half;

  // Every load starts a new period, i.e. a clk_out rising edge.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (at_wrap) begin
          if (enable) load = 1'b1;
          else state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_nxt = (state_d == ST_RUN);

  always_comb begin
    phase_d      = load ? strobe_phase : phase_q;
    edge_count_d = load ? edge_count_q + CNT_ONE : edge_count_q;
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      edge_count_q <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      edge_count_q <= edge_count_d;
    end
  end

  adc_clk_div_core #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_core (
    .aclk   (aclk),
    .resetn (resetn),
    .load   (load),
    .run_nxt(run_nxt),
    .div_eff(div_eff),
    .pos    (pos),
    .d_act  (d_act),
    .at_wrap(at_wrap),
    .clk_out(clk_out)
  );

  // Strobe phase clamped to the last position of the period.
  assign span  = {d_act, 1'b0} - ONE;
  assign p_eff = (phase_q > span) ? span : phase_q;

  assign clk_running   = (state_q == ST_RUN);
  assign sample_strobe = (state_q == ST_RUN) && (pos == p_eff);
  assign edge_count    = edge_count_q;

endmodule

// File: tb/tb_adc_clk_gen.sv
// Scoreboard bench for adc_clk_gen.
// Directed segments push expected per-cycle outputs; a monitor compares.
module tb_adc_clk_gen;

  typedef struct {
    int          cyc;
    logic        clk;
    logic        run;
    logic        stb;
    logic [31:0] ec;
  } exp_t;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  div_half = '0;
  logic [8:0]  strobe_phase = '0;
  logic        clk_out;
  logic        clk_running;
  logic        sample_strobe;
  logic [31:0] edge_count;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  adc_clk_gen #(
    .DIV_WIDTH(8),
    .CNT_WIDTH(32)
  ) dut (
    .aclk         (aclk),
    .resetn       (resetn),
    .enable       (enable),
    .div_half     (div_half),
    .strobe_phase (strobe_phase),
    .clk_out      (clk_out),
    .clk_running  (clk_running),
    .sample_strobe(sample_strobe),
    .edge_count   (edge_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic push(input int c, input logic k, input logic r,
                      input logic s, input logic [31:0] e);
    exp_t x;
    x.cyc = c; x.clk = k; x.run = r; x.stb = s; x.ec = e;
    exp_q.push_back(x);
  endtask

  task automatic push_idle(input int c0, input int c1, input int e);
    for (int c = c0; c <= c1; c++) push(c, 1'b0, 1'b0, 1'b0, e);
  endtask

  // n full periods of half-length d, strobe phase ph, first edge count e0+1.
  task automatic push_periods(input int start, input int d, input int ph,
                              input int n, input int e0);
    int pp;
    pp = (ph > 2 * d - 1) ? 2 * d - 1 : ph;
    for (int k = 0; k < n; k++)
      for (int p = 0; p < 2 * d; p++)
        push(start + k * 2 * d + p, p < d, 1'b1, p == pp, e0 + k + 1);
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) @(negedge aclk);
  endtask

  // Monitor: outputs are presented every cycle; compare where expected.
  always @(negedge aclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed cyc=%0d no sample taken", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if (clk_out !== x.clk || clk_running !== x.run ||
          sample_strobe !== x.stb || edge_count !== x.ec) begin
        errors++;
        $display("FAIL out cyc=%0d got clk=%b run=%b stb=%b ec=%0d want clk=%b run=%b stb=%b ec=%0d",
                 cyc, clk_out, clk_running, sample_strobe, edge_count,
                 x.clk, x.run, x.stb, x.ec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle, including divisor-0 start at cycle 10.
    push_idle(1, 10, 0);
    goto_cyc(3);
    resetn = 1'b1;
    goto_cyc(10);
    div_half = 8'd0; strobe_phase = 9'd0; enable = 1'b1;
    push_periods(11, 1, 0, 3, 0);
    goto_cyc(16);
    enable = 1'b0;
    push_idle(17, 20, 3);
    // Steady run d=4 strobe at pos 5; 11th period is the one changed mid-way.
    goto_cyc(20);
    div_half = 8'd4; strobe_phase = 9'd5; enable = 1'b1;
    push_periods(21, 4, 5, 11, 3);
    // div_half 4->2 at pos 2 of period starting at 101.
    goto_cyc(103);
    div_half = 8'd2;
    push_periods(109, 2, 5, 3, 14);
    // Reload d=3 with clamped phase 9 -> pos 5 at next boundary.
    goto_cyc(119);
    div_half = 8'd3; strobe_phase = 9'd9;
    push_periods(121, 3, 9, 1, 17);
    // Drop enable at pos 1: period completes, then idle.
    goto_cyc(122);
    enable = 1'b0;
    push_idle(127, 132, 18);
    // Phase clamp: d=2, phase 9 -> pos 3.
    goto_cyc(132);
    div_half = 8'd2; strobe_phase = 9'd9; enable = 1'b1;
    push_periods(133, 2, 9, 3, 18);
    push(145, 1'b1, 1'b1, 1'b0, 22);
    push(146, 1'b1, 1'b1, 1'b0, 22);
    // Async reset at pos 1 while clk_out high.
    goto_cyc(146);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({clk_out, clk_running, sample_strobe} !== 3'b000 || edge_count !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got clk=%b run=%b stb=%b ec=%0d want all 0",
               clk_out, clk_running, sample_strobe, edge_count);
    end
    push_idle(147, 149, 0);
    goto_cyc(149);
    resetn = 1'b1;
    push_periods(150, 2, 9, 1, 0);
    goto_cyc(152);
    enable = 1'b0;
    push_idle(154, 156, 1);
    goto_cyc(158);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
